// File: rtl/inst_ram_responder_pkg.sv
// Shared types and helpers for the instruction RAM responder and its word array.
// The optional same-cycle write forwarding is selected by RISCAT_MEM_WR_FORWARD_EN.
package riscat_mem_pkg;

    localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

    typedef enum logic {
        CLEAR,
        READY
    } mem_state_t;

    function automatic logic [29:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off[31:2];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/inst_ram_responder_ram_array_1r1w.sv
// Word array with one synchronous read port and one byte-enabled write port.
// No reset and read-first ordering, so it maps directly onto block RAM.
module ram_array_1r1w #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
    output logic [31:0]                    rd_data,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
    input  logic [31:0]                    wr_data,
    input  logic [3:0]                     wr_be
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/inst_ram_responder.sv
// Fetch-side instruction RAM responder: address decode, fault flagging, post-reset
// clear sweep and read latency pipeline. RISCAT_MEM_WR_FORWARD_EN enables write forwarding.
module inst_ram_responder
    import riscat_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter int          READ_LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rd_ram_addr,
    output logic [31:0] rd_ram_data,
    output logic        rd_addr_fault,
    input  logic        wr_ram_en,
    input  logic [31:0] wr_ram_addr,
    input  logic [31:0] wr_ram_data,
    input  logic [3:0]  wr_ram_be,
    output logic        mem_ready
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_IDX   = 30'(DEPTH_WORDS);
    localparam mem_state_t  RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    mem_state_t    state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;
    logic          clr_we;

    logic [29:0]   rd_idx, wr_idx;
    logic          rd_fault, wr_ok;

    logic          arr_we;
    logic [AW-1:0] arr_waddr;
    logic [31:0]   arr_wdata;
    logic [3:0]    arr_wbe;
    logic [31:0]   ram_q, ram_word;

    logic          vld_p0, nop_p0, fault_p0;
    logic [31:0]   data_p0, data_p1, data_p2;
    logic          fault_p1, fault_p2;

    assign rd_idx   = word_index(rd_ram_addr, BASE_ADDR);
    assign wr_idx   = word_index(wr_ram_addr, BASE_ADDR);
    assign rd_fault = (rd_ram_addr[1:0] != 2'b00) || (rd_idx >= DEPTH_IDX);
    assign wr_ok    = mem_ready && wr_ram_en && (wr_ram_be != 4'b0000) &&
                      (wr_ram_addr[1:0] == 2'b00) && (wr_idx < DEPTH_IDX);

    // Clear sequencer: one NOP write per cycle, then READY until the next reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
        endcase
    end

    assign mem_ready = (state == READY);

    // The sweep and the external port never overlap, since writes need mem_ready
    always_comb begin
        arr_we    = clr_we || wr_ok;
        arr_waddr = clr_we ? clr_cnt : wr_idx[AW-1:0];
        arr_wdata = clr_we ? RISCV_NOP : wr_ram_data;
        arr_wbe   = clr_we ? 4'hF : wr_ram_be;
    end

    ram_array_1r1w #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (ram_q),
        .wr_en   (arr_we),
        .wr_addr (arr_waddr),
        .wr_data (arr_wdata),
        .wr_be   (arr_wbe)
    );

    // Stage p0: read sampled into the array, decode flags registered alongside it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0   <= 1'b0;
            nop_p0   <= 1'b0;
            fault_p0 <= 1'b0;
        end else begin
            vld_p0   <= 1'b1;
            nop_p0   <= !mem_ready || rd_fault;
            fault_p0 <= mem_ready && rd_fault;
        end
    end

`ifdef RISCAT_MEM_WR_FORWARD_EN
    logic        fwd_p0;
    logic [31:0] fwd_data_p0;
    logic [3:0]  fwd_be_p0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_p0      <= 1'b0;
            fwd_data_p0 <= '0;
            fwd_be_p0   <= '0;
        end else begin
            fwd_p0      <= wr_ok && (wr_idx == rd_idx);
            fwd_data_p0 <= wr_ram_data;
            fwd_be_p0   <= wr_ram_be;
        end
    end

    // The array is read-first, so merging onto its output yields the written word
    assign ram_word = fwd_p0 ? merge_bytes(ram_q, fwd_data_p0, fwd_be_p0) : ram_q;
`else
    assign ram_word = ram_q;
`endif

    assign data_p0 = !vld_p0 ? 32'h0 : (nop_p0 ? RISCV_NOP : ram_word);

    // Stages p1/p2: extra output registers for READ_LATENCY 2 and 3
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_p1  <= '0;
            data_p2  <= '0;
            fault_p1 <= 1'b0;
            fault_p2 <= 1'b0;
        end else begin
            data_p1  <= data_p0;
            data_p2  <= data_p1;
            fault_p1 <= fault_p0;
            fault_p2 <= fault_p1;
        end
    end

    assign rd_ram_data   = (READ_LATENCY <= 1) ? data_p0 :
                           (READ_LATENCY == 2) ? data_p1 : data_p2;
    assign rd_addr_fault = (READ_LATENCY <= 1) ? fault_p0 :
                           (READ_LATENCY == 2) ? fault_p1 : fault_p2;

endmodule

// File: tb/tb_inst_ram_responder.sv
// Bench for inst_ram_responder: three 64-word instances (latency 1..3) under a scoreboard
// and a 16-word instance for sweep timing. Define RISCAT_MEM_WR_FORWARD_EN to test forwarding.
`timescale 1ns/1ps
module tb_inst_ram_responder;

    localparam int          DEPTH  = 64;
    localparam int          SDEPTH = 16;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] rd_ram_addr = '0;
    logic        wr_ram_en = 1'b0;
    logic [31:0] wr_ram_addr = '0;
    logic [31:0] wr_ram_data = '0;
    logic [3:0]  wr_ram_be = '0;

    logic [31:0] rd_data [3];
    logic        rd_fault [3];
    logic        rdy [3];
    logic [31:0] s_data;
    logic        s_fault;
    logic        s_rdy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inst_ram_responder #(
            .DEPTH_WORDS(DEPTH), .READ_LATENCY(g + 1),
            .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1)
        ) u_dut (
            .clk(clk), .reset_n(reset_n),
            .rd_ram_addr(rd_ram_addr), .rd_ram_data(rd_data[g]), .rd_addr_fault(rd_fault[g]),
            .wr_ram_en(wr_ram_en), .wr_ram_addr(wr_ram_addr), .wr_ram_data(wr_ram_data),
            .wr_ram_be(wr_ram_be), .mem_ready(rdy[g])
        );
    end

    inst_ram_responder #(
        .DEPTH_WORDS(SDEPTH), .READ_LATENCY(1),
        .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1)
    ) u_small (
        .clk(clk), .reset_n(reset_n),
        .rd_ram_addr(rd_ram_addr), .rd_ram_data(s_data), .rd_addr_fault(s_fault),
        .wr_ram_en(wr_ram_en), .wr_ram_addr(wr_ram_addr), .wr_ram_data(wr_ram_data),
        .wr_ram_be(wr_ram_be), .mem_ready(s_rdy)
    );

    // Reference model for the 64-word instances
    typedef struct packed {
        logic [31:0] d;
        logic        f;
    } exp_t;

    logic [31:0] m_mem [DEPTH];
    int          m_cnt = 0;
    bit          m_ready = 1'b0;
    exp_t        sb [3][$];

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    always @(negedge reset_n) begin
        m_cnt   = 0;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) sb[k].delete();
    end

    always @(posedge clk) begin
        if (reset_n) begin
            exp_t e;
            bit   wr_commit;
            wr_commit = m_ready && wr_ram_en && (wr_ram_addr[1:0] == 2'b00) &&
                        (wr_ram_addr < 32'(DEPTH * 4));
            if (!m_ready) begin
                e = {NOP, 1'b0};
            end else if ((rd_ram_addr[1:0] != 2'b00) || (rd_ram_addr >= 32'(DEPTH * 4))) begin
                e = {NOP, 1'b1};
            end else begin
                e.d = m_mem[rd_ram_addr[7:2]];
                e.f = 1'b0;
`ifdef RISCAT_MEM_WR_FORWARD_EN
                if (wr_commit && (wr_ram_addr[7:2] == rd_ram_addr[7:2]))
                    e.d = bmerge(e.d, wr_ram_data, wr_ram_be);
`endif
            end
            if (!m_ready) begin
                m_mem[m_cnt] = NOP;
                m_cnt++;
                if (m_cnt == DEPTH) m_ready = 1'b1;
            end else if (wr_commit) begin
                m_mem[wr_ram_addr[7:2]] = bmerge(m_mem[wr_ram_addr[7:2]], wr_ram_data, wr_ram_be);
            end
            for (int k = 0; k < 3; k++) sb[k].push_back(e);
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 3; k++) begin
                while (sb[k].size() > k) begin
                    exp_t e;
                    e = sb[k].pop_front();
                    vectors++;
                    if ({rd_data[k], rd_fault[k]} !== {e.d, e.f}) begin
                        miscompares++;
                        $display("FAIL sb_lat%0d: got data=%h fault=%b, expected data=%h fault=%b",
                                 k + 1, rd_data[k], rd_fault[k], e.d, e.f);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        wr_ram_en   = 1'b0;
        wr_ram_addr = '0;
        wr_ram_data = '0;
        wr_ram_be   = '0;
        rd_ram_addr = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({rd_data[k], rd_fault[k], rdy[k]} !== {32'h0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL %s_lat%0d: got data=%h fault=%b ready=%b, expected all zero",
                         tag, k + 1, rd_data[k], rd_fault[k], rdy[k]);
            end
        end
        vectors++;
        if ({s_data, s_fault, s_rdy} !== {32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_small: got data=%h fault=%b ready=%b, expected all zero",
                     tag, s_data, s_fault, s_rdy);
        end
    endtask

    // Counts edges after release; optionally attempts a write to word 0 mid-sweep
    task automatic sweep_and_check(input string tag, input bit poke_write);
        for (int c = 1; c <= DEPTH + 1; c++) begin
            @(negedge clk);
            vectors++;
            if (s_rdy !== (c >= SDEPTH)) begin
                miscompares++;
                $display("FAIL %s_small_ready@%0d: got %b, expected %b", tag, c, s_rdy, c >= SDEPTH);
            end
            vectors++;
            if (rdy[0] !== (c >= DEPTH)) begin
                miscompares++;
                $display("FAIL %s_ready@%0d: got %b, expected %b", tag, c, rdy[0], c >= DEPTH);
            end
            if (c == SDEPTH + 1) begin
                vectors++;
                if ({s_data, s_fault} !== {NOP, 1'b0}) begin
                    miscompares++;
                    $display("FAIL %s_small_read0: got %h/%b, expected %h/0", tag, s_data, s_fault, NOP);
                end
            end
            if (c == DEPTH + 1) begin
                vectors++;
                if ({rd_data[0], rd_fault[0]} !== {NOP, 1'b0}) begin
                    miscompares++;
                    $display("FAIL %s_read0: got %h/%b, expected %h/0", tag, rd_data[0], rd_fault[0], NOP);
                end
            end
            if (poke_write && c == 2) begin
                wr_ram_en = 1'b1; wr_ram_addr = 32'h0; wr_ram_data = 32'h1234_5678; wr_ram_be = 4'hF;
            end else begin
                wr_ram_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 reset_n = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_hold");
        reset_n = 1'b1;
    endtask

    task automatic test_sweep_timing();
        sweep_and_check("sweep", 1'b1);
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        wr_ram_en = 1'b1; wr_ram_addr = 32'h40; wr_ram_data = 32'hDEAD_BEEF; wr_ram_be = 4'hF;
        @(negedge clk);
        wr_ram_data = 32'h1122_3344; wr_ram_be = 4'b0101;
        @(negedge clk);
        wr_ram_en = 1'b0; rd_ram_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rd_ram_addr = 32'h0;
            vectors++;
            if ({rd_data[k], rd_fault[k]} !== {32'hDE22_BE44, 1'b0}) begin
                miscompares++;
                $display("FAIL byte_merge_lat%0d: got %h/%b, expected DE22BE44/0",
                         k + 1, rd_data[k], rd_fault[k]);
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] addrs [3];
        logic        faults [3];
        addrs  = '{32'h42, 32'(DEPTH * 4), 32'h44};
        faults = '{1'b1, 1'b1, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rd_ram_addr = addrs[i];
            @(negedge clk);
            vectors++;
            if ({rd_data[0], rd_fault[0]} !== {NOP, faults[i]}) begin
                miscompares++;
                $display("FAIL fault_%h: got %h/%b, expected %h/%b",
                         addrs[i], rd_data[0], rd_fault[0], NOP, faults[i]);
            end
        end
        rd_ram_addr = 32'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_same_cycle();
        logic [31:0] want;
`ifdef RISCAT_MEM_WR_FORWARD_EN
        want = 32'h5555_5555;
`else
        want = 32'hAAAA_AAAA;
`endif
        @(negedge clk);
        wr_ram_en = 1'b1; wr_ram_addr = 32'h80; wr_ram_data = 32'hAAAA_AAAA; wr_ram_be = 4'hF;
        @(negedge clk);
        wr_ram_data = 32'h5555_5555; rd_ram_addr = 32'h80;
        @(negedge clk);
        wr_ram_en = 1'b0;
        vectors++;
        if (rd_data[0] !== want) begin
            miscompares++;
            $display("FAIL same_cycle: got %h, expected %h", rd_data[0], want);
        end
        @(negedge clk);
        vectors++;
        if (rd_data[0] !== 32'h5555_5555) begin
            miscompares++;
            $display("FAIL after_write: got %h, expected 55555555", rd_data[0]);
        end
        rd_ram_addr = 32'h0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rd_ram_addr = 32'($urandom_range(0, 71) * 4);
            if ($urandom_range(0, 7) == 0) rd_ram_addr += 32'($urandom_range(1, 3));
            wr_ram_en   = ($urandom_range(0, 1) == 1);
            wr_ram_addr = 32'($urandom_range(0, 71) * 4);
            if ($urandom_range(0, 7) == 0) wr_ram_addr += 32'($urandom_range(1, 3));
            wr_ram_data = $urandom;
            wr_ram_be   = 4'($urandom_range(0, 15));
            if (i % 5 == 0) wr_ram_addr = rd_ram_addr;
        end
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midsweep();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (7) @(negedge clk);
        vectors++;
        if ({rd_data[0], rdy[0]} !== {NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL midsweep_pre: got %h/%b, expected %h/0", rd_data[0], rdy[0], NOP);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_zero_outputs("midsweep_async");
        @(negedge clk);
        reset_n = 1'b1;
        sweep_and_check("restart", 1'b0);
    endtask

    initial begin
        test_reset();
        test_sweep_timing();
        test_byte_write();
        test_fault();
        test_same_cycle();
        test_back_to_back();
        test_reset_midsweep();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
